// File: rtl/isa_pnp_pkg.sv
// Shared constants for the ISA Plug-and-Play configuration block: port
// addresses, register indices, state encodings and isolation patterns.
package isa_pnp_pkg;

  localparam logic [1:0] ST_WFK     = 2'd0;
  localparam logic [1:0] ST_SLEEP   = 2'd1;
  localparam logic [1:0] ST_ISOLATE = 2'd2;
  localparam logic [1:0] ST_CONFIG  = 2'd3;

  localparam logic [11:0] ADDR_PORT  = 12'h279;
  localparam logic [11:0] WDATA_PORT = 12'hA79;

  localparam logic [7:0] IDX_RD_PORT = 8'h00;
  localparam logic [7:0] IDX_ISOL    = 8'h01;
  localparam logic [7:0] IDX_CFG_CTL = 8'h02;
  localparam logic [7:0] IDX_WAKE    = 8'h03;
  localparam logic [7:0] IDX_CSN     = 8'h06;
  localparam logic [7:0] IDX_ACT     = 8'h30;
  localparam logic [7:0] IDX_IO_HI   = 8'h60;
  localparam logic [7:0] IDX_IO_LO   = 8'h61;
  localparam logic [7:0] IDX_IRQ     = 8'h70;

  localparam logic [7:0] ISO_PAT_A = 8'h55;
  localparam logic [7:0] ISO_PAT_B = 8'hAA;
  localparam int         ID_BITS   = 72;

  function automatic logic [7:0] iso_pattern(input logic second);
    return second ? ISO_PAT_B : ISO_PAT_A;
  endfunction

endpackage

// File: rtl/isa_pnp_isolator.sv
// Serial-isolation tracker: walks the 72-bit identifier two reads per bit and
// flags a lost arbitration when a zero-bit card sees 0x55 then 0xAA.
module isa_pnp_isolator
  import isa_pnp_pkg::*;
#(
  parameter logic [31:0] VENDOR_ID = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        rd_rise,
  input  logic [71:0] serial_id,
  input  logic [7:0]  data_in,
  output logic        cur_bit,
  output logic        phase,
  output logic        done,
  output logic        lose
);

  logic [6:0]  bit_idx;
  logic        saw_a;
  logic [71:0] id_eff;

  // A tied-off serial_id falls back to the vendor/product half from the parameter
  assign id_eff  = (serial_id == '0) ? {40'h0, VENDOR_ID} : serial_id;
  assign done    = (bit_idx == 7'(ID_BITS));
  assign cur_bit = done ? 1'b0 : id_eff[bit_idx];
  assign lose    = rd_rise & ~done & ~cur_bit & phase & saw_a & (data_in == ISO_PAT_B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx <= '0;
      phase   <= 1'b0;
      saw_a   <= 1'b0;
    end else if (clear) begin
      bit_idx <= '0;
      phase   <= 1'b0;
      saw_a   <= 1'b0;
    end else if (rd_rise && !done) begin
      if (!phase) begin
        phase <= 1'b1;
        saw_a <= ~cur_bit & (data_in == ISO_PAT_A);
      end else begin
        phase <= 1'b0;
        saw_a <= 1'b0;
        if (!lose) bit_idx <= bit_idx + 7'd1;
      end
    end
  end

endmodule

// File: rtl/isa_pnp_config_ctrl.sv
// ISA PnP card-side configuration controller: decodes the address/write-data/
// read-data ports, runs the WFK/SLEEP/ISOLATE/CONFIG state machine and holds the config registers.
module isa_pnp_config_ctrl
  import isa_pnp_pkg::*;
#(
  parameter logic [31:0] VENDOR_ID = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] isa_addr,
  input  logic [7:0]  isa_data_in,
  input  logic        isa_iow_n,
  input  logic        isa_ior_n,
  input  logic        isa_aen,
  input  logic        config_mode,
  input  logic [71:0] serial_id,
  output logic [7:0]  isa_data_out,
  output logic        isa_data_oe,
  output logic        key_return,
  output logic [1:0]  pnp_state,
  output logic [7:0]  csn,
  output logic [9:0]  read_port,
  output logic        activate,
  output logic [15:0] io_base,
  output logic [3:0]  irq_sel
);

  logic       iow_q, ior_q, cfg_q, cfg_q2;
  logic [7:0] index;
  logic       iow_fall, ior_fall, ior_rise_raw, ior_rise;
  logic       cfg_rise, cfg_fall, decode_on;
  logic       wr_addr, wr_data, rd_hit, iso_read, wake_iso;
  logic       iso_bit, iso_phase, iso_done, iso_lose;
  logic [7:0] rd_val;
  logic       rd_drive;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iow_q  <= 1'b1;
      ior_q  <= 1'b1;
      cfg_q  <= 1'b0;
      cfg_q2 <= 1'b0;
    end else begin
      iow_q  <= isa_iow_n;
      ior_q  <= isa_ior_n;
      cfg_q  <= config_mode;
      cfg_q2 <= cfg_q;
    end
  end

  assign iow_fall     = iow_q & ~isa_iow_n & ~isa_aen;
  assign ior_fall     = ior_q & ~isa_ior_n & ~isa_aen;
  assign ior_rise_raw = ~ior_q & isa_ior_n;
  assign ior_rise     = ior_rise_raw & ~isa_aen;
  assign cfg_rise     = cfg_q & ~cfg_q2;
  assign cfg_fall     = ~cfg_q & cfg_q2;

  assign decode_on = (pnp_state != ST_WFK);
  assign wr_addr   = iow_fall & decode_on & (isa_addr == ADDR_PORT);
  assign wr_data   = iow_fall & decode_on & (isa_addr == WDATA_PORT);
  assign rd_hit    = decode_on & (isa_addr == {2'b00, read_port});
  assign iso_read  = rd_hit & (pnp_state == ST_ISOLATE) & (index == IDX_ISOL);
  assign wake_iso  = wr_data & (index == IDX_WAKE) & (pnp_state == ST_SLEEP) &
                     (isa_data_in == 8'h00) & (csn == 8'h00);

  isa_pnp_isolator #(.VENDOR_ID(VENDOR_ID)) u_isolator (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (wake_iso),
    .rd_rise  (ior_rise & iso_read),
    .serial_id(serial_id),
    .data_in  (isa_data_in),
    .cur_bit  (iso_bit),
    .phase    (iso_phase),
    .done     (iso_done),
    .lose     (iso_lose)
  );

  always_comb begin
    rd_val   = 8'h00;
    rd_drive = 1'b0;
    if (pnp_state == ST_CONFIG) begin
      rd_drive = 1'b1;
      case (index)
        IDX_CSN:   rd_val = csn;
        IDX_ACT:   rd_val = {7'b0, activate};
        IDX_IO_HI: rd_val = io_base[15:8];
        IDX_IO_LO: rd_val = io_base[7:0];
        IDX_IRQ:   rd_val = {4'b0, irq_sel};
        default:   rd_val = 8'h00;
      endcase
    end else if (pnp_state == ST_ISOLATE && index == IDX_ISOL) begin
      // Zero bits and a finished sequence leave the bus floating (reads 0xFF)
      if (iso_done) begin
        rd_val = 8'hFF;
      end else if (iso_bit) begin
        rd_drive = 1'b1;
        rd_val   = iso_pattern(iso_phase);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isa_data_oe  <= 1'b0;
      isa_data_out <= 8'h00;
    end else if (ior_rise_raw) begin
      isa_data_oe  <= 1'b0;
      isa_data_out <= 8'h00;
    end else if (ior_fall && rd_hit) begin
      isa_data_oe  <= rd_drive;
      isa_data_out <= rd_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pnp_state  <= ST_WFK;
      index      <= 8'h00;
      csn        <= 8'h00;
      read_port  <= 10'h000;
      activate   <= 1'b0;
      io_base    <= 16'h0000;
      irq_sel    <= 4'h0;
      key_return <= 1'b0;
    end else begin
      key_return <= 1'b0;
      if (wr_addr) index <= isa_data_in;
      if (wr_data) begin
        case (index)
          IDX_RD_PORT:
            if (pnp_state == ST_ISOLATE || pnp_state == ST_CONFIG)
              read_port <= {isa_data_in, 2'b11};
          IDX_WAKE:
            if (pnp_state == ST_SLEEP) begin
              if (isa_data_in == 8'h00 && csn == 8'h00) pnp_state <= ST_ISOLATE;
              else if (isa_data_in == csn && csn != 8'h00) pnp_state <= ST_CONFIG;
            end else if (isa_data_in != csn) begin
              pnp_state <= ST_SLEEP;
            end
          IDX_CFG_CTL: begin
            if (isa_data_in[0]) begin
              activate <= 1'b0;
              io_base  <= 16'h0000;
              irq_sel  <= 4'h0;
            end
            if (isa_data_in[2]) csn <= 8'h00;
            if (isa_data_in[1]) begin
              pnp_state  <= ST_WFK;
              key_return <= 1'b1;
            end
          end
          IDX_CSN:
            if (pnp_state == ST_ISOLATE) begin
              csn       <= isa_data_in;
              pnp_state <= ST_CONFIG;
            end else if (pnp_state == ST_CONFIG) begin
              csn <= isa_data_in;
            end
          IDX_ACT:   if (pnp_state == ST_CONFIG) activate      <= isa_data_in[0];
          IDX_IO_HI: if (pnp_state == ST_CONFIG) io_base[15:8] <= isa_data_in;
          IDX_IO_LO: if (pnp_state == ST_CONFIG) io_base[7:0]  <= isa_data_in;
          IDX_IRQ:   if (pnp_state == ST_CONFIG) irq_sel       <= isa_data_in[3:0];
          default: ;
        endcase
      end
      if (iso_lose) pnp_state <= ST_SLEEP;
      if (pnp_state == ST_WFK && cfg_rise) pnp_state <= ST_SLEEP;
      // Losing the key level overrides everything, and is silent on key_return
      if (cfg_fall) pnp_state <= ST_WFK;
    end
  end

endmodule

// File: tb/tb_isa_pnp_config_ctrl.sv
// Randomized bench for isa_pnp_config_ctrl against a transaction-level PnP card model.
module tb_isa_pnp_config_ctrl;

  localparam logic [31:0] VID = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] isa_addr;
  logic [7:0]  isa_data_in;
  logic        isa_iow_n, isa_ior_n, isa_aen, config_mode;
  logic [71:0] serial_id;
  logic [7:0]  isa_data_out;
  logic        isa_data_oe, key_return;
  logic [1:0]  pnp_state;
  logic [7:0]  csn;
  logic [9:0]  read_port;
  logic        activate;
  logic [15:0] io_base;
  logic [3:0]  irq_sel;

  isa_pnp_config_ctrl #(.VENDOR_ID(VID)) dut (
    .clk(clk), .rst_n(rst_n), .isa_addr(isa_addr), .isa_data_in(isa_data_in),
    .isa_iow_n(isa_iow_n), .isa_ior_n(isa_ior_n), .isa_aen(isa_aen),
    .config_mode(config_mode), .serial_id(serial_id),
    .isa_data_out(isa_data_out), .isa_data_oe(isa_data_oe), .key_return(key_return),
    .pnp_state(pnp_state), .csn(csn), .read_port(read_port), .activate(activate),
    .io_base(io_base), .irq_sel(irq_sel)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, kr_cnt = 0;
  always @(negedge clk) if (key_return === 1'b1) kr_cnt++;

  // card model: 0=WFK 1=SLEEP 2=ISOLATE 3=CONFIG
  int          m_state, m_bit, m_reads;
  logic        m_first_ok, m_act;
  logic [7:0]  m_csn, m_idx;
  logic [9:0]  m_rp;
  logic [15:0] m_io;
  logic [3:0]  m_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic m_reset();
    m_state = 0; m_bit = 0; m_reads = 0; m_first_ok = 0; m_act = 0;
    m_csn = 0; m_idx = 0; m_rp = 0; m_io = 0; m_irq = 0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".state"}, 32'(pnp_state), 32'(m_state));
    chk({tag, ".csn"},   32'(csn),       32'(m_csn));
    chk({tag, ".rport"}, 32'(read_port), 32'(m_rp));
    chk({tag, ".act"},   32'(activate),  32'(m_act));
    chk({tag, ".io"},    32'(io_base),   32'(m_io));
    chk({tag, ".irq"},   32'(irq_sel),   32'(m_irq));
  endtask

  task automatic m_write(input logic [11:0] a, input logic [7:0] d, input logic aen_v,
                         output int kr_exp);
    kr_exp = 0;
    if (aen_v || m_state == 0) return;
    if (a == 12'h279) m_idx = d;
    else if (a == 12'hA79) begin
      case (m_idx)
        8'h00: if (m_state >= 2) m_rp = {d, 2'b11};
        8'h02: begin
          if (d[0]) begin m_act = 0; m_io = 0; m_irq = 0; end
          if (d[2]) m_csn = 0;
          if (d[1]) begin m_state = 0; kr_exp = 1; end
        end
        8'h03: begin
          if (m_state == 1) begin
            if (d == 0 && m_csn == 0) begin m_state = 2; m_bit = 0; m_reads = 0; end
            else if (d == m_csn && m_csn != 0) m_state = 3;
          end else if (d != m_csn) m_state = 1;
        end
        8'h06: if (m_state == 2) begin m_csn = d; m_state = 3; end
               else if (m_state == 3) m_csn = d;
        8'h30: if (m_state == 3) m_act = d[0];
        8'h60: if (m_state == 3) m_io[15:8] = d;
        8'h61: if (m_state == 3) m_io[7:0] = d;
        8'h70: if (m_state == 3) m_irq = d[3:0];
        default: ;
      endcase
    end
  endtask

  task automatic m_read(input logic [7:0] bus, output logic drv, output logic [7:0] val);
    logic [71:0] id;
    logic        b, lost;
    drv = 0; val = 0;
    id = (serial_id == 72'h0) ? {40'h0, VID} : serial_id;
    if (m_state == 3) begin
      drv = 1;
      case (m_idx)
        8'h06:   val = m_csn;
        8'h30:   val = {7'b0, m_act};
        8'h60:   val = m_io[15:8];
        8'h61:   val = m_io[7:0];
        8'h70:   val = {4'h0, m_irq};
        default: val = 8'h00;
      endcase
    end else if (m_state == 2 && m_idx == 8'h01 && m_bit < 72) begin
      b = id[m_bit];
      if (b) begin drv = 1; val = (m_reads == 0) ? 8'h55 : 8'hAA; end
      else if (m_reads == 0) m_first_ok = (bus == 8'h55);
      lost = !b && m_reads == 1 && m_first_ok && bus == 8'hAA;
      if (m_reads == 0) m_reads = 1;
      else begin
        m_reads = 0;
        if (lost) m_state = 1; else m_bit++;
      end
    end
  endtask

  task automatic bus_wr(input logic [11:0] a, input logic [7:0] d, input logic aen_v);
    int kr_exp;
    m_write(a, d, aen_v, kr_exp);
    kr_cnt = 0;
    @(negedge clk);
    isa_addr = a; isa_data_in = d; isa_aen = aen_v; isa_iow_n = 1'b0;
    repeat (2) @(negedge clk);
    isa_iow_n = 1'b1;
    repeat (2) @(negedge clk);
    isa_aen = 1'b0;
    chk("key_return", 32'(kr_cnt), 32'(kr_exp));
  endtask

  task automatic bus_rd(input logic [7:0] bus, output logic oe_any, output logic [7:0] first_val);
    logic       exp_drv;
    logic [7:0] exp_val;
    m_read(bus, exp_drv, exp_val);
    @(negedge clk);
    isa_addr = {2'b00, read_port}; isa_data_in = bus; isa_ior_n = 1'b0;
    @(negedge clk);
    oe_any = isa_data_oe; first_val = isa_data_out;
    repeat (2) begin @(negedge clk); oe_any |= isa_data_oe; end
    isa_ior_n = 1'b1;
    @(negedge clk);
    chk("oe_off", 32'(isa_data_oe), 32'h0);
    @(negedge clk);
    chk("rd_oe", 32'(oe_any), 32'(exp_drv));
    if (exp_drv) chk("rd_data", 32'(first_val), 32'(exp_val));
  endtask

  task automatic cfg_toggle();
    kr_cnt = 0;
    @(negedge clk); config_mode = 1'b0;
    repeat (3) @(negedge clk);
    m_state = 0;
    chk("cfg_fall.state", 32'(pnp_state), 32'h0);
    chk("cfg_fall.kr", 32'(kr_cnt), 32'h0);
    config_mode = 1'b1;
    repeat (3) @(negedge clk);
    m_state = 1;
  endtask

  task automatic wr_reg(input logic [7:0] idx, input logic [7:0] d);
    bus_wr(12'h279, idx, 1'b0);
    bus_wr(12'hA79, d, 1'b0);
  endtask

  function automatic logic [7:0] pick_idx();
    logic [7:0] l [10] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h06, 8'h30, 8'h60, 8'h61, 8'h70, 8'h00};
    l[9] = 8'($urandom);
    return l[$urandom_range(0, 9)];
  endfunction

  function automatic logic [7:0] pick_data();
    logic [7:0] r = 8'($urandom);
    if (m_idx == 8'h03) begin
      case ($urandom_range(0, 2))
        0: return 8'h00;
        1: return m_csn;
        default: return r;
      endcase
    end
    if (m_idx == 8'h02 && $urandom_range(0, 7) != 0) return r & 8'hFD;
    return r;
  endfunction

  function automatic logic [7:0] pick_bus();
    case ($urandom_range(0, 2))
      0: return 8'h55;
      1: return 8'hAA;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       oe_a;
    logic [7:0] v;
    rst_n = 1'b0; isa_addr = 0; isa_data_in = 0; isa_iow_n = 1; isa_ior_n = 1;
    isa_aen = 0; config_mode = 0; serial_id = 0;
    m_reset();
    #1;
    chk_regs("reset");
    chk("reset.oe", 32'(isa_data_oe), 32'h0);
    chk("reset.dout", 32'(isa_data_out), 32'h0);
    chk("reset.kr", 32'(key_return), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // key detected: SLEEP exactly two clocks later
    @(negedge clk); config_mode = 1'b1;
    @(negedge clk); chk("wake.1clk", 32'(pnp_state), 32'h0);
    @(negedge clk); chk("wake.2clk", 32'(pnp_state), 32'h1);
    m_state = 1;

    // isolation of a bit=1 card, then CSN assignment
    serial_id = {32'($urandom), 32'($urandom), 8'h01};
    wr_reg(8'h03, 8'h00);
    chk("iso.state", 32'(pnp_state), 32'h2);
    wr_reg(8'h00, 8'h80);
    chk("iso.rport", 32'(read_port), 32'h203);
    bus_wr(12'h279, 8'h01, 1'b0);
    bus_rd(8'h00, oe_a, v); chk("iso.rd1", 32'(v), 32'h55);
    bus_rd(8'h00, oe_a, v); chk("iso.rd2", 32'(v), 32'hAA);
    wr_reg(8'h06, 8'h01);
    chk("csn.val", 32'(csn), 32'h1);
    chk("csn.state", 32'(pnp_state), 32'h3);

    // configuration registers
    wr_reg(8'h60, 8'h03); wr_reg(8'h61, 8'hF0); wr_reg(8'h30, 8'h01);
    chk("cfg.io", 32'(io_base), 32'h03F0);
    chk("cfg.act", 32'(activate), 32'h1);
    bus_wr(12'h279, 8'h60, 1'b0);
    bus_rd(8'h00, oe_a, v); chk("cfg.rd60", 32'(v), 32'h03);
    bus_wr(12'h279, 8'h45, 1'b0);
    bus_rd(8'h00, oe_a, v); chk("cfg.rd_other", 32'(v), 32'h00);
    chk_regs("cfg");

    // config control 0x07: reset, WFK, clear csn, one key_return pulse
    wr_reg(8'h02, 8'h07);
    chk("cc.kr", 32'(kr_cnt), 32'h1);
    chk("cc.state", 32'(pnp_state), 32'h0);
    chk("cc.csn", 32'(csn), 32'h0);
    chk("cc.act", 32'(activate), 32'h0);

    // bit=0 card loses arbitration on 0x55/0xAA
    cfg_toggle();
    serial_id = {32'($urandom), 32'($urandom), 8'h02};
    wr_reg(8'h03, 8'h00);
    wr_reg(8'h00, 8'h80);
    bus_wr(12'h279, 8'h01, 1'b0);
    bus_rd(8'h55, oe_a, v); chk("lose.oe1", 32'(oe_a), 32'h0);
    bus_rd(8'hAA, oe_a, v); chk("lose.oe2", 32'(oe_a), 32'h0);
    chk("lose.state", 32'(pnp_state), 32'h1);
    chk_regs("lose");

    serial_id = {32'($urandom), 32'($urandom), 8'($urandom)};
    for (int it = 0; it < 400; it++) begin
      if (m_state == 0) cfg_toggle();
      else begin
        case ($urandom_range(0, 5))
          0: bus_wr(12'h279, pick_idx(), 1'b0);
          1: bus_wr(12'hA79, pick_data(), 1'b0);
          2, 3: bus_rd(pick_bus(), oe_a, v);
          4: bus_wr($urandom_range(0, 1) ? 12'h279 : 12'hA79, 8'($urandom), 1'b1);
          default: begin
            bus_wr(12'h279, pick_idx(), 1'b0);
            bus_wr(12'hA79, pick_data(), 1'b0);
          end
        endcase
      end
      chk_regs("rnd");
    end

    // full 72-bit walk, then reads float
    cfg_toggle();
    wr_reg(8'h02, 8'h04);
    serial_id = {32'($urandom), 32'($urandom), 8'($urandom)};
    wr_reg(8'h03, 8'h00);
    wr_reg(8'h00, 8'h40);
    bus_wr(12'h279, 8'h01, 1'b0);
    for (int i = 0; i < 144; i++) bus_rd(8'h00, oe_a, v);
    bus_rd(8'h00, oe_a, v);
    chk("done.oe", 32'(oe_a), 32'h0);
    chk("done.state", 32'(pnp_state), 32'h2);
    wr_reg(8'h06, 8'h05);
    chk_regs("done");

    // reset while a card is driving an isolation read
    cfg_toggle();
    wr_reg(8'h02, 8'h04);
    serial_id = {32'($urandom), 32'($urandom), 8'h01};
    wr_reg(8'h03, 8'h00);
    wr_reg(8'h00, 8'h80);
    bus_wr(12'h279, 8'h01, 1'b0);
    @(negedge clk); isa_addr = {2'b00, read_port}; isa_ior_n = 1'b0;
    @(negedge clk); chk("rst.oe_before", 32'(isa_data_oe), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.oe_now", 32'(isa_data_oe), 32'h0);
    chk("rst.state", 32'(pnp_state), 32'h0);
    config_mode = 1'b0; isa_ior_n = 1'b1;
    @(negedge clk); chk("rst.oe_next", 32'(isa_data_oe), 32'h0);
    rst_n = 1'b1;
    m_reset();
    @(negedge clk);
    chk_regs("rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
